// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector ASIP memory stage: default sizes, sequencer
// state encoding and the OpType code that selects a full-vector transfer.
package vec_mem_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_ELEM_W = 8;
    localparam int DEF_ADDR_W = 8;

    localparam logic [1:0] OPTYPE_VECTOR = 2'b11;

    typedef enum logic [1:0] {
        VMS_IDLE    = 2'd0,
        VMS_ACCESS  = 2'd1,
        VMS_WAIT_RD = 2'd2,
        VMS_DONE    = 2'd3
    } vms_state_t;

endpackage

// File: rtl/vec_load_buffer.sv
// Lane-capture register that assembles a load result one element at a time.
// A lane write takes priority over the clear of the upper lanes.
module vec_load_buffer #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        we_i,
    input  logic [ELEM_W-1:0]       wdata_i,
    input  logic                    clr_upper_i,
    output logic [LANES*ELEM_W-1:0] data_o
);

    logic [LANES-1:0][ELEM_W-1:0] lane_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (we_i[l])
                    lane_q[l] <= wdata_i;
                else if (clr_upper_i && (l != 0))
                    lane_q[l] <= '0;
            end
        end
    end

    assign data_o = lane_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// Memory-stage sequencer: serializes scalar/vector loads and stores onto a
// single-element data memory port and reports when the stage can release.
module vec_mem_sequencer
    import vec_mem_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    MemWE,
    input  logic                    mem_re,
    input  logic [1:0]              OpType,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*ELEM_W-1:0] store_data,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [ELEM_W-1:0]       dmem_wdata,
    input  logic [ELEM_W-1:0]       dmem_rdata,
    output logic [LANES*ELEM_W-1:0] load_data,
    output logic                    Mem_Finished
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    vms_state_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        last_q;
    logic                    store_q;
    logic [LANES*ELEM_W-1:0] sdata_q;
    logic                    req_q;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ELEM_W-1:0]       wdata_q;

    logic                    accept;
    logic                    clr_upper;
    logic                    cap_en;
    logic [CNT_W-1:0]        cap_idx;
    logic [LANES-1:0]        cap_we;

    assign accept = (state_q == VMS_IDLE) && start && (MemWE || mem_re);

    // Port outputs are registered one step ahead: the values driven during
    // access i are loaded at the edge that enters (or stays in) that access.
    // sdata_q is a shift register presenting the next store lane at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VMS_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            store_q <= 1'b0;
            sdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                VMS_IDLE: begin
                    if (accept) begin
                        store_q <= MemWE;
                        last_q  <= (OpType == OPTYPE_VECTOR) ? CNT_W'(LANES-1) : '0;
                        cnt_q   <= '0;
                        sdata_q <= store_data >> ELEM_W;
                        req_q   <= 1'b1;
                        we_q    <= MemWE;
                        addr_q  <= base_addr;
                        wdata_q <= MemWE ? store_data[ELEM_W-1:0] : '0;
                        state_q <= VMS_ACCESS;
                    end
                end
                VMS_ACCESS: begin
                    if (cnt_q == last_q) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        state_q <= store_q ? VMS_DONE : VMS_WAIT_RD;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        addr_q  <= addr_q + ADDR_W'(1);
                        wdata_q <= store_q ? sdata_q[ELEM_W-1:0] : '0;
                        sdata_q <= sdata_q >> ELEM_W;
                    end
                end
                VMS_WAIT_RD: state_q <= VMS_DONE;
                VMS_DONE:    state_q <= VMS_IDLE;
                default:     state_q <= VMS_IDLE;
            endcase
        end
    end

    // Read data trails its request by one cycle, so access i fills lane i-1
    // and the final lane lands in WAIT_RD.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = cnt_q - CNT_W'(1);
        if ((state_q == VMS_ACCESS) && !store_q && (cnt_q != '0)) begin
            cap_en = 1'b1;
        end else if (state_q == VMS_WAIT_RD) begin
            cap_en  = 1'b1;
            cap_idx = last_q;
        end
        for (int l = 0; l < LANES; l++)
            cap_we[l] = cap_en && (cap_idx == CNT_W'(l));
    end

    assign clr_upper = accept && !MemWE && (OpType != OPTYPE_VECTOR);

    vec_load_buffer #(
        .LANES  (LANES),
        .ELEM_W (ELEM_W)
    ) u_load_buf (
        .clk         (clk),
        .rst         (rst),
        .we_i        (cap_we),
        .wdata_i     (dmem_rdata),
        .clr_upper_i (clr_upper),
        .data_o      (load_data)
    );

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign Mem_Finished = (state_q == VMS_DONE) || ((state_q == VMS_IDLE) && !accept);

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a one-cycle-latency memory model.
module tb_vec_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        MemWE;
    logic        mem_re;
    logic [1:0]  OpType;
    logic [7:0]  base_addr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic [7:0]  dmem_rdata;
    logic [31:0] load_data;
    logic        Mem_Finished;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];

    vec_mem_sequencer #(.LANES(4), .ELEM_W(8), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .MemWE        (MemWE),
        .mem_re       (mem_re),
        .OpType       (OpType),
        .base_addr    (base_addr),
        .store_data   (store_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .load_data    (load_data),
        .Mem_Finished (Mem_Finished)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_req && dmem_we)  mem[dmem_addr] <= dmem_wdata;
        if (dmem_req && !dmem_we) dmem_rdata <= mem[dmem_addr];
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic s, input logic we, input logic re, input logic [1:0] op,
                         input logic [7:0] b, input logic [31:0] d);
        start = s; MemWE = we; mem_re = re; OpType = op; base_addr = b; store_data = d;
    endtask

    // Called from T1; returns in the IDLE cycle after DONE.
    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (Mem_Finished) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_timeout: Mem_Finished never rose", name); end
        tick();
    endtask

    task automatic run_op(input logic we, input logic re, input logic [1:0] op,
                          input logic [7:0] b, input logic [31:0] d, input string name);
        drive(1, we, re, op, b, d);
        tick();
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        wait_done(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        dmem_rdata = 8'h00;
        tick(); tick(); tick();
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b1) begin errors++; $display("FAIL rst_mf: got %b want 1", Mem_Finished); end
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 18'h0) begin
            errors++; $display("FAIL rst_dmem: got req=%b we=%b addr=%h wdata=%h want all 0",
                               dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        checks++;
        if (load_data !== 32'h0) begin errors++; $display("FAIL rst_load: got %h want 0", load_data); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vec_store();
        logic [31:0] d = 32'hDDCCBBAA;
        logic [7:0]  ea;
        drive(1, 1, 0, 2'b11, 8'h10, d);
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b0) begin errors++; $display("FAIL vst_mf_t0: got %b want 0", Mem_Finished); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            // Garbage operands with start held high: must be ignored outside IDLE.
            drive(1, 0, 1, 2'b01, 8'h99, 32'h12345678);
            ea = 8'h10 + 8'(i-1);
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== ea || dmem_wdata !== d[8*(i-1) +: 8]) begin
                errors++; $display("FAIL vst_T%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 %h %h",
                                   i, dmem_req, dmem_we, dmem_addr, dmem_wdata, ea, d[8*(i-1) +: 8]);
            end
            checks++;
            if (Mem_Finished !== 1'b0) begin errors++; $display("FAIL vst_mf_T%0d: got %b want 0", i, Mem_Finished); end
        end
        tick();
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL vst_T5: got mf=%b req=%b want 1 0", Mem_Finished, dmem_req);
        end
        tick();
        checks++;
        if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== d) begin
            errors++; $display("FAIL vst_mem: got %h want %h", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, d);
        end
    endtask

    task automatic test_vec_load();
        logic [7:0] ea;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03; mem[8'h23] = 8'h04;
        drive(1, 0, 1, 2'b11, 8'h20, 32'hFFFFFFFF);
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b0) begin errors++; $display("FAIL vld_mf_t0: got %b want 0", Mem_Finished); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
            ea = 8'h20 + 8'(i-1);
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== ea || Mem_Finished !== 1'b0) begin
                errors++; $display("FAIL vld_T%0d: got req=%b we=%b addr=%h mf=%b want 1 0 %h 0",
                                   i, dmem_req, dmem_we, dmem_addr, Mem_Finished, ea);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || Mem_Finished !== 1'b0) begin
            errors++; $display("FAIL vld_T5: got req=%b mf=%b want 0 0", dmem_req, Mem_Finished);
        end
        tick();
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b1 || load_data !== 32'h04030201) begin
            errors++; $display("FAIL vld_T6: got mf=%b data=%h want 1 04030201", Mem_Finished, load_data);
        end
        tick();
    endtask

    task automatic test_scalar_load();
        for (int a = 8'h30; a <= 8'h33; a++) mem[a] = 8'hFF;
        run_op(0, 1, 2'b11, 8'h30, 32'h0, "sld_pre");
        checks++;
        if (load_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL sld_pre: got %h want ffffffff", load_data); end
        mem[8'h40] = 8'h5A;
        drive(1, 0, 1, 2'b00, 8'h40, 32'h0);
        tick();
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'h40) begin
            errors++; $display("FAIL sld_T1: got req=%b we=%b addr=%h want 1 0 40", dmem_req, dmem_we, dmem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || Mem_Finished !== 1'b0) begin
            errors++; $display("FAIL sld_T2: got req=%b mf=%b want 0 0", dmem_req, Mem_Finished);
        end
        tick();
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b1 || load_data !== 32'h0000005A) begin
            errors++; $display("FAIL sld_T3: got mf=%b data=%h want 1 0000005a", Mem_Finished, load_data);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] ea;
        drive(1, 1, 0, 2'b11, 8'hFE, 32'h44332211);
        for (int i = 1; i <= 4; i++) begin
            tick();
            drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
            ea = 8'hFE + 8'(i-1);
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== ea) begin
                errors++; $display("FAIL wrap_T%0d: got req=%b addr=%h want 1 %h", i, dmem_req, dmem_addr, ea);
            end
        end
        tick();
        wait_done("wrap");
        checks++;
        if (mem[8'hFE] !== 8'h11 || mem[8'h01] !== 8'h44) begin
            errors++; $display("FAIL wrap_mem: got fe=%h 01=%h want 11 44", mem[8'hFE], mem[8'h01]);
        end
    endtask

    task automatic test_conflict();
        int bad = 0;
        drive(1, 1, 1, 2'b01, 8'h50, 32'h00000077);
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b0) begin errors++; $display("FAIL cfl_mf_t0: got %b want 0", Mem_Finished); end
        tick();
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'h50 || dmem_wdata !== 8'h77) begin
            errors++; $display("FAIL cfl_T1: got req=%b we=%b addr=%h wdata=%h want 1 1 50 77",
                               dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL cfl_T2: got mf=%b req=%b want 1 0", Mem_Finished, dmem_req);
        end
        tick();
        checks++;
        if (mem[8'h50] !== 8'h77) begin errors++; $display("FAIL cfl_mem: got %h want 77", mem[8'h50]); end
        drive(1, 0, 0, 2'b11, 8'h60, 32'hA5A5A5A5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!Mem_Finished || dmem_req) bad++;
            tick();
        end
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL noop_start: got %0d busy cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 2'b00, 8'h70, 32'h000000AB);
        tick();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_wdata !== 8'hAB) begin
            errors++; $display("FAIL b2b_T1: got req=%b wdata=%h want 1 ab", dmem_req, dmem_wdata);
        end
        tick();
        store_data = 32'h000000CD;
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL b2b_done: got mf=%b req=%b want 1 0", Mem_Finished, dmem_req);
        end
        tick();
        @(negedge clk);
        checks++;
        if (Mem_Finished !== 1'b0) begin errors++; $display("FAIL b2b_accept: got mf=%b want 0", Mem_Finished); end
        tick();
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 8'h70 || dmem_wdata !== 8'hCD) begin
            errors++; $display("FAIL b2b_T4: got req=%b addr=%h wdata=%h want 1 70 cd", dmem_req, dmem_addr, dmem_wdata);
        end
        tick();
        wait_done("b2b");
    endtask

    task automatic test_reset_mid_load();
        drive(1, 0, 1, 2'b11, 8'h20, 32'h0);
        tick();
        drive(0, 0, 0, 2'b00, 8'h00, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || load_data !== 32'h0 || Mem_Finished !== 1'b1) begin
            errors++; $display("FAIL rmid_T3: got req=%b data=%h mf=%b want 0 0 1", dmem_req, load_data, Mem_Finished);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0) begin errors++; $display("FAIL rmid_T4: got req=%b want 0", dmem_req); end
        tick();
        run_op(0, 1, 2'b11, 8'h20, 32'h0, "rmid_reload");
        checks++;
        if (load_data !== 32'h04030201) begin errors++; $display("FAIL rmid_reload: got %h want 04030201", load_data); end
    endtask

    initial begin
        test_reset();
        test_vec_store();
        test_vec_load();
        test_scalar_load();
        test_wrap();
        test_conflict();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
